// File: rtl/register_pkg.sv
// Shared sample-path constants and width helpers for the sample register bank.
//   DEF_WIDTH / DEF_DEPTH : default sample width and bank depth used by the ADC path
//   sum_width(w, d)       : width of a running sum of d samples of w bits
//   cnt_width(d)          : width of a fill counter that can reach d
package register_pkg;

    localparam int unsigned DEF_WIDTH = 12;
    localparam int unsigned DEF_DEPTH = 16;

    function automatic int unsigned sum_width(input int unsigned width, input int unsigned depth);
        return width + $clog2(depth);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned SUM_W = sum_width(DEF_WIDTH, DEF_DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEF_DEPTH);

endpackage

// File: rtl/register.sv
// Single capture register with load enable and synchronous active-low reset.
//   clk          : system clock
//   reset_n      : synchronous, active-low clear
//   write_enable : load data on this edge
//   data         : value to capture
//   q            : stored value
module register #(
    parameter int unsigned width = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             write_enable,
    input  logic [width-1:0] data,
    output logic [width-1:0] q
);

    // Capture flop
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= '0;
        end else if (write_enable) begin
            q <= data;
        end
    end

endmodule

// File: rtl/sample_register_bank.sv
// DEPTH-deep shift bank of WIDTH-bit samples with freeze, clear, fill tracking
// and a running sum / moving average.
//   clk, reset_n  : clock and synchronous active-low reset
//   data          : sample to shift in
//   write_enable  : accept data on this edge
//   freeze        : hold all state (blocks write_enable, not clear)
//   clear         : synchronous clear of bank, count and sum
//   q / q_oldest  : newest (stage 0) and oldest (stage DEPTH-1) samples
//   sum / avg     : sum of all stages and sum >> log2(DEPTH)
//   count / full  : number of valid samples (saturating) and count == DEPTH
module sample_register_bank
    import register_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [WIDTH-1:0]                      data,
    input  logic                                  write_enable,
    input  logic                                  freeze,
    input  logic                                  clear,
    output logic [WIDTH-1:0]                      q,
    output logic [WIDTH-1:0]                      q_oldest,
    output logic [sum_width(WIDTH, DEPTH)-1:0]    sum,
    output logic [WIDTH-1:0]                      avg,
    output logic [cnt_width(DEPTH)-1:0]           count,
    output logic                                  full
);

    localparam int unsigned LOG2_D = $clog2(DEPTH);
    localparam int unsigned S_W    = sum_width(WIDTH, DEPTH);
    localparam int unsigned C_W    = cnt_width(DEPTH);

    // Reject non power-of-two or too-shallow banks at elaboration
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "sample_register_bank: DEPTH must be a power of two >= 2");
    end

    logic             shift_en;
    logic             stage_rst_n;
    logic [WIDTH-1:0] stage [DEPTH];

    // Freeze blocks shifting; clear is folded into the per-stage reset
    assign shift_en    = write_enable & ~freeze;
    assign stage_rst_n = reset_n & ~clear;

    // Shift chain: stage 0 takes the new sample, stage i takes stage i-1
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            register #(.width(WIDTH)) u_reg (
                .clk          (clk),
                .reset_n      (stage_rst_n),
                .write_enable (shift_en),
                .data         (data),
                .q            (stage[i])
            );
        end else begin : g_tail
            register #(.width(WIDTH)) u_reg (
                .clk          (clk),
                .reset_n      (stage_rst_n),
                .write_enable (shift_en),
                .data         (stage[i-1]),
                .q            (stage[i])
            );
        end
    end

    assign q        = stage[0];
    assign q_oldest = stage[DEPTH-1];

    // Running sum, fill count and full flag; empty stages hold 0 so the
    // incremental update needs no special case while filling
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            sum   <= '0;
            count <= '0;
            full  <= 1'b0;
        end else if (shift_en) begin
            sum <= sum + S_W'(data) - S_W'(stage[DEPTH-1]);
            if (count != C_W'(DEPTH)) begin
                count <= count + C_W'(1);
            end
            if (count == C_W'(DEPTH - 1)) begin
                full <= 1'b1;
            end
        end
    end

    // Truncating mean of the registered sum
    assign avg = sum[S_W-1 -: WIDTH];

    // LOG2_D documents the shift amount implied by the slice above
    logic unused_log2;
    assign unused_log2 = (LOG2_D == 0);

endmodule

// File: doc/sample_register_bank.md
# sample_register_bank

Parametrised multi-stage successor to the single 12-bit capture register: a DEPTH-deep shift bank of WIDTH-bit samples with write enable, freeze, synchronous clear, fill tracking and a running sum/average. It sits between the ADC sample path and the display/averaging logic, holding the last DEPTH accepted samples and providing the newest sample and a moving average every cycle.

## Interface
- WIDTH, 12, bits per sample
- DEPTH, 16, number of stages; power of two, ≥ 2
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  synchronous, active-low reset
- data  input  WIDTH  sample to shift in
- write_enable  input  1  accept `data` on this edge
- freeze  input  1  hold all state; blocks write_enable
- clear  input  1  synchronous clear of bank, count and sum (active-high)
- q  output  WIDTH  newest stored sample (stage 0)
- q_oldest  output  WIDTH  stage DEPTH-1
- sum  output  WIDTH+log2(DEPTH)  sum of all DEPTH stages
- avg  output  WIDTH  sum >> log2(DEPTH)
- count  output  log2(DEPTH)+1  number of valid samples, saturates at DEPTH
- full  output  1  count == DEPTH; qualifies avg as a true mean

## Operation
- Priority per edge: reset_n=0 > clear=1 > freeze=1 > write_enable=1 > hold.
- Reset/clear: every stage, q, q_oldest, sum, avg, count cleared to 0; full=0.
- Write (write_enable=1, freeze=0, clear=0): stage0 ← data, stage i ← stage i-1; former stage DEPTH-1 discarded.
- sum updated incrementally on the same edge: sum ← sum + data − stage[DEPTH-1] (old value). Because empty stages hold 0, no special case needed while filling. sum width WIDTH+log2(DEPTH) never overflows (max DEPTH·(2^WIDTH−1)).
- count ← count+1 on write while count < DEPTH; stays at DEPTH once full (wrap: oldest dropped, count unchanged).
- avg is combinationally derived from registered sum (truncating shift, no rounding); valid only when full=1, underestimates while filling.
- freeze=1: write_enable ignored, all outputs hold; clear still acts.
- clear and write_enable together: clear wins, data dropped, count=0 after edge.
- write_enable with X/unknown data is the user's fault; no checking.

## Timing
- Write latency 1 cycle: data sampled at edge k appears on q, sum, avg, count after edge k.
- q_oldest reflects a sample DEPTH writes later (not DEPTH cycles: idle cycles do not shift).
- full rises after the DEPTH-th accepted write, same edge count reaches DEPTH; falls only on reset/clear.
- Reset mid-fill or mid-stream: all state 0 after the edge at which reset_n is sampled low; resumes from empty on first write after reset_n=1.
- No combinational path from inputs to outputs.

## Structure
- Package `register_pkg`: localparam helpers for log2(DEPTH)-derived widths (SUM_W, CNT_W) and the default WIDTH/DEPTH constants shared with the ADC path.
- Sub-module: the existing `register` (parameter width, ports data, clk, write_enable, reset_n, q) instantiated once per stage in a generate loop, with its write_enable driven by the bank's gated shift enable and reset_n driven by reset_n AND NOT clear. Sum/count/full logic lives in the top.
- Elaboration-time assertion that DEPTH is a power of two ≥ 2.

## Test plan
Bench uses WIDTH=12, DEPTH=4, 20 ns clock.
- Reset: reset_n=0 two cycles with random prior contents -> q, q_oldest, sum, avg, count all 0, full=0.
- Fill: write 12'h001, 12'h002, 12'h003, 12'h004 back-to-back -> after 4th edge q=12'h004, q_oldest=12'h001, sum=10, avg=2, count=4, full=1; after 3rd edge full=0, count=3.
- Wrap: continue writing 12'h005 -> q_oldest=12'h002, sum=14, avg=3, count stays 4.
- Enables: write_enable=0 with data=12'h5A5 for 3 cycles, then freeze=1 with write_enable=1 -> all outputs unchanged throughout.
- Saturation: write 12'hFFF four times -> sum=14'h3FFC, avg=12'hFFF, no overflow.
- Clear vs write: clear=1 and write_enable=1 with data=12'h0AA same edge -> count=0, sum=0, q=0; next write 12'h0AA -> q=12'h0AA, count=1, full=0.
